figure_select_controller: RTL and testbench
===========================================

Name: figure_select_controller

Overview:
- Owns the figure-selection state driving the draw system: a 3x3 cursor grid (circle, square, triangle / oval, rectangle, diamond / hexagon, pentagon, star) plus full-screen mode.
- Takes the five already-filtered button levels, edge-detects them, applies auto-repeat and queues one command.
- Commits queued commands only at frame start, so the picture never changes mid-frame.
- Runs on the system clock, alongside the button filters, feeding the one-hot selects and completeScreen of the drawing datapath.

Parameters:
- COLS, 3, grid columns.
- ROWS, 3, grid rows. COLS*ROWS = number of figure selects.
- REPEAT_DELAY, 30, frames a direction must be held before the first auto-repeat.
- REPEAT_RATE, 8, frames between subsequent auto-repeats.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- up  in  1  filtered button level.
- down  in  1  filtered button level.
- left  in  1  filtered button level.
- right  in  1  filtered button level.
- select  in  1  filtered button level.
- vsync  in  1  VSync from the VGA controller, active-low, already in clk domain.
- fig_sel  out  COLS*ROWS  one-hot figure select; bit i = grid index i, row-major.
- cursor  out  4  current grid index, 0..COLS*ROWS-1.
- full_screen  out  1  completeScreen request to the draw system.
- frame_start  out  1  one-cycle pulse on the falling edge of vsync.

Behaviour:
- Reset (clk edge with rst=1):
  - cursor=0, fig_sel=1, full_screen=0, frame_start=0.
  - State BROWSE; pending queue empty; repeat counters cleared; edge registers loaded with the current input levels, so buttons held through reset produce no event.
- Edge detect: one register per button; a press event is level=1 and previous=0.
- Command queue: single entry, holding one of SEL, UP, DOWN, LEFT, RIGHT.
  - Same-cycle priority: SEL > UP > DOWN > LEFT > RIGHT.
  - A new event overwrites the pending entry only if it has strictly higher priority; otherwise it is dropped.
- Auto-repeat:
  - Per-frame counter for the held direction; only the highest-priority held direction counts.
  - Counter resets on release, or when a different direction becomes highest priority.
  - When the count reaches REPEAT_DELAY, and every REPEAT_RATE frames after that, generate a synthetic press of that direction in the frame_start cycle.
  - select never auto-repeats.
- frame_start: asserted the cycle after vsync is seen going 1->0, registered.
- Commit: in the frame_start cycle, if the queue is non-empty, apply the command. Outputs change on the next clk edge (1-cycle latency from frame_start). The queue then clears.
- Event arriving in the same cycle as frame_start: if it beats the pending entry it is committed in that cycle; otherwise it is dropped.
- State BROWSE:
  - UP: row-1 with wrap (row 0 -> ROWS-1).
  - DOWN: row+1 with wrap.
  - LEFT: col-1 with wrap inside the same row (col 0 -> COLS-1, row unchanged).
  - RIGHT: col+1 with wrap.
  - SEL: go to FULL, full_screen=1.
- State FULL:
  - Directions are ignored and discarded at commit; cursor is frozen.
  - SEL: back to BROWSE, full_screen=0, same cursor.
- Arithmetic:
  - row = cursor / COLS, col = cursor % COLS, computed by a comparator chain, not a divider.
  - fig_sel = 1 << cursor, registered; always exactly one bit set.
- Reset mid-frame or with an entry pending: the entry is discarded; nothing from before reset commits.
- Missing vsync: commands stay pending indefinitely; outputs stay stable.

Decomposition:
- Shared package: command encoding (CMD_NONE, CMD_SEL, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT), state encoding (ST_BROWSE, ST_FULL), and grid index constants for the nine figures.
- One sub-module, button_repeat: edge detect plus frame-based auto-repeat for a single direction, instantiated four times. Queue, priority and FSM stay in the top.

Test Plan:
- Reset with right held, then vsync toggled 3 frames -> cursor=0, fig_sel=9'b000000001, full_screen=0; no move.
- Press right once, then frame_start -> one cycle after frame_start, cursor=1, fig_sel=9'b000000010. Press left twice across 2 frames -> cursor=2 (wraps in row 0).
- cursor=0, press up -> cursor=6. Press down -> cursor=0.
- up and right rising in the same cycle, one frame -> cursor=6 only; right is dropped.
- cursor=4, press select -> full_screen=1. Press right -> no change. Press select -> full_screen=0, cursor=4.
- Hold right for 46 frames with REPEAT_DELAY=30, REPEAT_RATE=8 -> moves at the first press plus frames 30, 38, 46, final cursor=1 (4 moves from 0 with wrap). Assert rst mid-hold with a command pending -> cursor=0 and no commit afterwards.

Source files
------------

// File: rtl/figure_select_controller_pkg.sv
// Shared encodings for the figure-select controller: queued commands,
// browse/full-screen states and the grid index of each figure.
package figure_select_controller_pkg;

  // Lower encoding = higher priority; CMD_NONE marks an empty queue.
  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_SEL   = 3'd1,
    CMD_UP    = 3'd2,
    CMD_DOWN  = 3'd3,
    CMD_LEFT  = 3'd4,
    CMD_RIGHT = 3'd5
  } cmd_t;

  typedef enum logic {
    ST_BROWSE = 1'b0,
    ST_FULL   = 1'b1
  } state_t;

  localparam logic [3:0] FIG_CIRCLE    = 4'd0;
  localparam logic [3:0] FIG_SQUARE    = 4'd1;
  localparam logic [3:0] FIG_TRIANGLE  = 4'd2;
  localparam logic [3:0] FIG_OVAL      = 4'd3;
  localparam logic [3:0] FIG_RECTANGLE = 4'd4;
  localparam logic [3:0] FIG_DIAMOND   = 4'd5;
  localparam logic [3:0] FIG_HEXAGON   = 4'd6;
  localparam logic [3:0] FIG_PENTAGON  = 4'd7;
  localparam logic [3:0] FIG_STAR      = 4'd8;

  // True when cand should replace held in the single-entry queue.
  function automatic logic cmd_beats(input cmd_t cand, input cmd_t held);
    return (cand != CMD_NONE) && ((held == CMD_NONE) || (cand < held));
  endfunction

endpackage

// File: rtl/figure_select_controller_button_repeat.sv
// Edge detect plus frame-counted auto-repeat for one direction button.
module button_repeat #(
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic active,
  input  logic frame_start,
  output logic evt
);

  localparam int MAXC = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(MAXC + 1);

  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep_q, rep_d;
  logic [CW-1:0] last_cnt;
  logic          fire;

  // rep_q selects between the initial delay and the steady repeat period.
  always_comb begin
    prev_d   = level;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    fire     = 1'b0;
    last_cnt = rep_q ? CW'(REPEAT_RATE - 1) : CW'(REPEAT_DELAY - 1);
    if (!level || !active) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (frame_start) begin
      if (cnt_q == last_cnt) begin
        fire  = 1'b1;
        cnt_d = '0;
        rep_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign evt = (level & ~prev_q) | fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= level;
      cnt_q  <= '0;
      rep_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      rep_q  <= rep_d;
    end
  end

endmodule

// File: rtl/figure_select_controller.sv
// Figure-selection controller: queues one button command and commits it only
// at frame start, driving the one-hot figure select and full-screen request.
module figure_select_controller
  import figure_select_controller_pkg::*;
#(
  parameter int COLS         = 3,
  parameter int ROWS         = 3,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up,
  input  logic                 down,
  input  logic                 left,
  input  logic                 right,
  input  logic                 select,
  input  logic                 vsync,
  output logic [COLS*ROWS-1:0] fig_sel,
  output logic [3:0]           cursor,
  output logic                 full_screen,
  output logic                 frame_start
);

  localparam int NFIG = COLS * ROWS;

  logic            vs_prev_q, vs_prev_d;
  logic            fs_q, fs_d;
  logic            sel_prev_q, sel_prev_d;
  cmd_t            pend_q, pend_d;
  state_t          state_q, state_d;
  logic [3:0]      cursor_q, cursor_d;
  logic [NFIG-1:0] fig_sel_q, fig_sel_d;
  logic            full_q, full_d;

  logic            ev_up, ev_down, ev_left, ev_right, ev_sel;
  logic            act_up, act_down, act_left, act_right;
  cmd_t            ev_cmd, eff_cmd;
  logic [3:0]      row, row_base, col;

  // Only the highest-priority held direction may accumulate repeat frames.
  assign act_up    = up;
  assign act_down  = down & ~up;
  assign act_left  = left & ~up & ~down;
  assign act_right = right & ~up & ~down & ~left;

  button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_up (
    .clk(clk), .rst(rst), .level(up), .active(act_up), .frame_start(fs_q), .evt(ev_up));
  button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_down (
    .clk(clk), .rst(rst), .level(down), .active(act_down), .frame_start(fs_q), .evt(ev_down));
  button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_left (
    .clk(clk), .rst(rst), .level(left), .active(act_left), .frame_start(fs_q), .evt(ev_left));
  button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_right (
    .clk(clk), .rst(rst), .level(right), .active(act_right), .frame_start(fs_q), .evt(ev_right));

  assign ev_sel     = select & ~sel_prev_q;
  assign sel_prev_d = select;
  assign vs_prev_d  = vsync;
  assign fs_d       = vs_prev_q & ~vsync;

  // Row and row base address from a comparator chain over the row starts.
  always_comb begin
    row      = '0;
    row_base = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (cursor_q >= 4'(r * COLS)) begin
        row      = 4'(r);
        row_base = 4'(r * COLS);
      end
    end
    col = cursor_q - row_base;
  end

  always_comb begin
    ev_cmd = CMD_NONE;
    if (ev_sel)        ev_cmd = CMD_SEL;
    else if (ev_up)    ev_cmd = CMD_UP;
    else if (ev_down)  ev_cmd = CMD_DOWN;
    else if (ev_left)  ev_cmd = CMD_LEFT;
    else if (ev_right) ev_cmd = CMD_RIGHT;

    eff_cmd  = cmd_beats(ev_cmd, pend_q) ? ev_cmd : pend_q;
    pend_d   = eff_cmd;
    state_d  = state_q;
    cursor_d = cursor_q;

    if (fs_q) begin
      pend_d = CMD_NONE;
      case (state_q)
        ST_BROWSE: begin
          case (eff_cmd)
            CMD_SEL:   state_d = ST_FULL;
            CMD_UP:    cursor_d = (row == 4'd0) ? cursor_q + 4'((ROWS - 1) * COLS)
                                                : cursor_q - 4'(COLS);
            CMD_DOWN:  cursor_d = (row == 4'(ROWS - 1)) ? col : cursor_q + 4'(COLS);
            CMD_LEFT:  cursor_d = (col == 4'd0) ? cursor_q + 4'(COLS - 1) : cursor_q - 4'd1;
            CMD_RIGHT: cursor_d = (col == 4'(COLS - 1)) ? row_base : cursor_q + 4'd1;
            default:   ;
          endcase
        end
        ST_FULL: begin
          if (eff_cmd == CMD_SEL) state_d = ST_BROWSE;
        end
        default: state_d = ST_BROWSE;
      endcase
    end

    full_d    = (state_d == ST_FULL);
    fig_sel_d = {{(NFIG - 1){1'b0}}, 1'b1} << cursor_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q  <= vsync;
      fs_q       <= 1'b0;
      sel_prev_q <= select;
      pend_q     <= CMD_NONE;
      state_q    <= ST_BROWSE;
      cursor_q   <= FIG_CIRCLE;
      fig_sel_q  <= {{(NFIG - 1){1'b0}}, 1'b1};
      full_q     <= 1'b0;
    end else begin
      vs_prev_q  <= vs_prev_d;
      fs_q       <= fs_d;
      sel_prev_q <= sel_prev_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      fig_sel_q  <= fig_sel_d;
      full_q     <= full_d;
    end
  end

  assign fig_sel     = fig_sel_q;
  assign cursor      = cursor_q;
  assign full_screen = full_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_figure_select_controller.sv
// Bench for figure_select_controller: table of button/frame vectors plus
// hand-written corner sequences, checked through an expected-output queue.
module tb_figure_select_controller;

  localparam logic [4:0] B_N = 5'b00000;
  localparam logic [4:0] B_S = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  logic       clk = 1'b0;
  logic       rst, up, down, left, right, select, vsync;
  logic [8:0] fig_sel;
  logic [3:0] cursor;
  logic       full_screen, frame_start;

  int         checks = 0;
  int         errors = 0;
  logic [13:0] exp_q[$];
  logic       fs_prev = 1'b0;

  typedef struct {
    logic [4:0] btn;
    logic [3:0] cur;
    logic       full;
  } vec_t;
  vec_t vecs[24];

  always #5 clk = ~clk;

  figure_select_controller dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .select(select), .vsync(vsync), .fig_sel(fig_sel), .cursor(cursor),
    .full_screen(full_screen), .frame_start(frame_start));

  function automatic logic [13:0] pack_exp(input logic [3:0] c, input logic f);
    logic [8:0] one;
    one = 9'd1;
    return {f, one << c, c};
  endfunction

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic set_btn(input logic [4:0] m);
    {select, up, down, left, right} = m;
  endtask

  task automatic press(input logic [4:0] m);
    set_btn(m);
    @(posedge clk); #1;
    set_btn(B_N);
    @(posedge clk); #1;
  endtask

  task automatic do_frame(input logic [13:0] e);
    exp_q.push_back(e);
    vsync = 1'b0;
    @(posedge clk); #1;
    vsync = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Button edge lands exactly in the frame_start cycle.
  task automatic frame_with_press(input logic [4:0] m, input logic [13:0] e);
    exp_q.push_back(e);
    vsync = 1'b0;
    @(posedge clk); #1;
    vsync = 1'b1;
    set_btn(m);
    @(posedge clk); #1;
    set_btn(B_N);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Outputs are compared the cycle after each frame_start pulse.
  always @(negedge clk) begin
    if (fs_prev) begin
      check("fs_pulse_width", {13'd0, frame_start}, 14'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_frame got=%h exp=none", {full_screen, fig_sel, cursor});
      end else begin
        check("frame_commit", {full_screen, fig_sel, cursor}, exp_q.pop_front());
      end
    end
    fs_prev = frame_start;
  end

  initial begin
    vecs[0]  = '{B_R,       4'd1, 1'b0};
    vecs[1]  = '{B_L,       4'd0, 1'b0};
    vecs[2]  = '{B_L,       4'd2, 1'b0};
    vecs[3]  = '{B_R,       4'd0, 1'b0};
    vecs[4]  = '{B_U,       4'd6, 1'b0};
    vecs[5]  = '{B_D,       4'd0, 1'b0};
    vecs[6]  = '{5'b01001,  4'd6, 1'b0};
    vecs[7]  = '{B_D,       4'd0, 1'b0};
    vecs[8]  = '{B_D,       4'd3, 1'b0};
    vecs[9]  = '{B_R,       4'd4, 1'b0};
    vecs[10] = '{B_S,       4'd4, 1'b1};
    vecs[11] = '{B_R,       4'd4, 1'b1};
    vecs[12] = '{B_U,       4'd4, 1'b1};
    vecs[13] = '{B_S,       4'd4, 1'b0};
    vecs[14] = '{B_L,       4'd3, 1'b0};
    vecs[15] = '{B_D,       4'd6, 1'b0};
    vecs[16] = '{B_D,       4'd0, 1'b0};
    vecs[17] = '{B_U,       4'd6, 1'b0};
    vecs[18] = '{B_L,       4'd8, 1'b0};
    vecs[19] = '{B_R,       4'd6, 1'b0};
    vecs[20] = '{B_N,       4'd6, 1'b0};
    vecs[21] = '{5'b11001,  4'd6, 1'b1};
    vecs[22] = '{B_S,       4'd6, 1'b0};
    vecs[23] = '{B_D,       4'd0, 1'b0};

    // Reset with right held: no event once reset is released.
    set_btn(B_R);
    vsync = 1'b1;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {full_screen, fig_sel, cursor}, pack_exp(4'd0, 1'b0));
    check("reset_frame_start", {13'd0, frame_start}, 14'd0);
    @(posedge clk); #1;
    repeat (3) do_frame(pack_exp(4'd0, 1'b0));
    set_btn(B_N);
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].btn != B_N) press(vecs[i].btn);
      do_frame(pack_exp(vecs[i].cur, vecs[i].full));
    end

    // Queue overwrite only by strictly higher priority.
    press(B_R); press(B_D); press(B_L);
    do_frame(pack_exp(4'd3, 1'b0));
    press(B_D); press(B_R);
    do_frame(pack_exp(4'd6, 1'b0));

    // Events in the frame_start cycle.
    press(B_R);
    frame_with_press(B_U, pack_exp(4'd3, 1'b0));
    press(B_U);
    frame_with_press(B_R, pack_exp(4'd0, 1'b0));
    do_frame(pack_exp(4'd0, 1'b0));

    // Without vsync the command stays pending and outputs hold.
    press(B_R);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("no_vsync_hold", {full_screen, fig_sel, cursor}, pack_exp(4'd0, 1'b0));
    @(posedge clk); #1;
    do_frame(pack_exp(4'd1, 1'b0));
    press(B_L);
    do_frame(pack_exp(4'd0, 1'b0));

    // Auto-repeat: hold right for 46 frames.
    right = 1'b1;
    @(posedge clk); #1;
    for (int f = 1; f <= 46; f++) begin
      int mv;
      mv = 1 + int'(f >= 30) + int'(f >= 38) + int'(f >= 46);
      do_frame(pack_exp(4'(mv % 3), 1'b0));
    end

    // Reset while holding right with SEL pending.
    select = 1'b1;
    @(posedge clk); #1;
    select = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_mid_hold", {full_screen, fig_sel, cursor}, pack_exp(4'd0, 1'b0));
    @(posedge clk); #1;
    repeat (3) do_frame(pack_exp(4'd0, 1'b0));
    right = 1'b0;

    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
